pattern_line_arbiter: RTL and testbench
=======================================

# pattern_line_arbiter

Round-robin scheduler that shares one serial pattern output line between two requesters. Each requester presents a pattern word and a length. The block grants the line to one requester at a time and plays the pattern LSB-first, one bit per step period. A single on-chip prescaler times every step. The block sits between the pattern sources and the output pin, and replaces free-running per-source pattern generators.

## Interface
- CLK_DIV, 12500000, number of iCLK cycles per step; must be ≥ 2.
- PAT_W, 16, pattern word width; maximum frame length in steps.
- iCLK  in  1  system clock; all state changes on the rising edge.
- iRST_N  in  1  asynchronous, active-low reset.
- iREQ  in  2  per-requester request level; bit i belongs to requester i.
- iPAT0, iPAT1  in  PAT_W  pattern of requester 0 / 1; bit k is played in step k.
- iLEN0, iLEN1  in  5  frame length in steps; 0 means reject, values > PAT_W are clamped to PAT_W.
- iABORT  in  1  synchronous abort of the current frame.
- oGNT  out  2  one-hot grant; high for the whole PLAY state.
- oDONE  out  2  one-cycle pulse on normal completion of a frame; also pulses on a length-0 reject.
- oSIG  out  1  serial output line; 0 whenever no frame is playing.
- oBUSY  out  1  high in PLAY or GAP.
- oSTEP  out  4  current step index; 0 outside PLAY.

## Operation
- States: IDLE, PLAY, GAP. After reset: IDLE, oSIG=0, oGNT=0, oDONE=0, oBUSY=0, oSTEP=0, prescaler=0, last-served pointer=1, so requester 0 wins the first tie.
- **IDLE**:
  - If iREQ is nonzero, the winner is chosen on the next edge:
    - If only one requester is asserting, it wins.
    - If both are asserting, the requester not equal to the last-served pointer wins.
  - On that edge:
    - Latch the winner's iPAT and the clamped length.
    - Set oGNT to the winner.
    - Set the pointer to the winner.
    - Clear step and prescaler.
    - Enter PLAY.
  - Length-0 winner:
    - Do not enter PLAY and do not set oGNT.
    - Pulse oDONE for the winner and update the pointer.
    - Stay in IDLE.
- **PLAY**:
  - oSIG = latched_pat[step].
  - The prescaler counts 0..CLK_DIV-1. At CLK_DIV-1 it wraps to 0, which is a tick.
  - On a tick with step < len-1: step increments.
  - On a tick with step = len-1:
    - Pulse oDONE for the granted requester.
    - Clear oGNT.
    - Enter GAP.
  - Changes to iREQ, iPAT or iLEN during PLAY are ignored; the latched copy is used.
- **GAP**:
  - oSIG=0 and oGNT=0 for exactly CLK_DIV cycles (one inter-frame step).
  - Then enter IDLE.
  - Requests are not evaluated during GAP.
- **iABORT**:
  - In PLAY or GAP, iABORT forces IDLE on the next edge.
  - oSIG=0, oGNT=0, step=0, prescaler=0; no oDONE pulse.
  - The pointer keeps the aborted requester, so the other requester wins the next tie.
  - iABORT in IDLE has priority over a pending request: no grant is issued that cycle.
- Asynchronous reset mid-frame returns all outputs to their reset values immediately; no oDONE pulse.

## Timing
- Request-to-line latency:
  - iREQ is sampled at edge E0.
  - oGNT, oBUSY and oSIG = pat[0] are valid after E0.
  - This is a 1-cycle latency.
- Step k occupies cycles 1+k·CLK_DIV through (k+1)·CLK_DIV after E0.
- The frame ends at edge E0 + len·CLK_DIV:
  - oDONE is high for the following cycle only.
  - oGNT falls and GAP begins at the same edge.
- Earliest next grant:
  - GAP ends at E0 + (len+1)·CLK_DIV.
  - IDLE evaluates on the next edge.
  - Line-to-line spacing is therefore (len+1)·CLK_DIV + 1 cycles.
- All outputs are registered; oSIG never glitches between steps.

## Test plan
- CLK_DIV=4. iREQ=01, iPAT0=16'h0CDC, iLEN0=12, held for one cycle.
  - oSIG sequence, each value held 4 cycles: 0,0,1,1,1,0,1,1,0,0,1,1.
  - oDONE=01 one cycle after edge E0+48.
  - oBUSY drops at E0+52.
- Both iREQ=11 held continuously, lengths 3.
  - Grants alternate 01,10,01,10.
  - Each grant starts 17 cycles after the previous one.
- iLEN1=20, iPAT1=16'hFFFF: 16 high steps, then oDONE=10; the length is clamped.
- iLEN0=0 with iREQ=01:
  - oDONE=01 pulse one cycle later.
  - oGNT stays 00 and oBUSY stays 0.
- iABORT asserted in step 5 of a requester-0 frame:
  - Next cycle: IDLE, oSIG=0, oGNT=00, no oDONE.
  - A following tie with iREQ=11 grants requester 1.
- iRST_N pulsed low mid-PLAY:
  - All outputs go to 0 immediately.
  - After release, a tie grants requester 0 first.

Source files
------------

// File: rtl/pattern_line_arbiter.sv
// Two-requester round-robin scheduler driving one serial pattern line.
// Frames play LSB-first, one bit per prescaler step, followed by a one-step gap.
module pattern_line_arbiter #(
  parameter int CLK_DIV = 12500000,
  parameter int PAT_W   = 16
) (
  input  logic             iCLK,
  input  logic             iRST_N,
  input  logic [1:0]       iREQ,
  input  logic [PAT_W-1:0] iPAT0,
  input  logic [PAT_W-1:0] iPAT1,
  input  logic [4:0]       iLEN0,
  input  logic [4:0]       iLEN1,
  input  logic             iABORT,
  output logic [1:0]       oGNT,
  output logic [1:0]       oDONE,
  output logic             oSIG,
  output logic             oBUSY,
  output logic [3:0]       oSTEP
);

  localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

  state_t           state, state_n;
  logic [PW-1:0]    presc, presc_n;
  logic [3:0]       step, step_n;
  logic [4:0]       len, len_n;
  logic [PAT_W-1:0] pat, pat_n;
  logic             last, last_n;
  logic [1:0]       gnt_n, done_n;
  logic             sig_n, busy_n;
  logic             win, tick;
  logic [4:0]       win_len;

  function automatic logic [4:0] clamp_len(input logic [4:0] l);
    if (l > 5'(PAT_W)) return 5'(PAT_W);
    return l;
  endfunction

  // Tie goes to whichever requester was not served last.
  assign win     = iREQ[1] & (~iREQ[0] | ~last);
  assign win_len = win ? iLEN1 : iLEN0;
  assign tick    = (presc == PRESC_LAST);
  assign oSTEP   = step;

  always_comb begin
    state_n = state;
    presc_n = presc;
    step_n  = step;
    len_n   = len;
    pat_n   = pat;
    last_n  = last;
    gnt_n   = oGNT;
    done_n  = 2'b00;
    sig_n   = oSIG;
    busy_n  = oBUSY;
    case (state)
      IDLE: begin
        if (!iABORT && iREQ != 2'b00) begin
          last_n = win;
          if (win_len == 5'd0) begin
            done_n = win ? 2'b10 : 2'b01;
          end else begin
            state_n = PLAY;
            pat_n   = win ? iPAT1 : iPAT0;
            len_n   = clamp_len(win_len);
            gnt_n   = win ? 2'b10 : 2'b01;
            step_n  = 4'd0;
            presc_n = '0;
            sig_n   = pat_n[0];
            busy_n  = 1'b1;
          end
        end
      end
      PLAY: begin
        if (iABORT) begin
          state_n = IDLE;
          presc_n = '0;
          step_n  = 4'd0;
          gnt_n   = 2'b00;
          sig_n   = 1'b0;
          busy_n  = 1'b0;
        end else if (tick) begin
          presc_n = '0;
          if ({1'b0, step} == len - 5'd1) begin
            state_n = GAP;
            done_n  = oGNT;
            gnt_n   = 2'b00;
            step_n  = 4'd0;
            sig_n   = 1'b0;
          end else begin
            step_n = step + 4'd1;
            sig_n  = pat[step_n];
          end
        end else begin
          presc_n = presc + 1'b1;
        end
      end
      GAP: begin
        if (iABORT || tick) begin
          state_n = IDLE;
          presc_n = '0;
          busy_n  = 1'b0;
        end else begin
          presc_n = presc + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state <= IDLE;
      presc <= '0;
      step  <= 4'd0;
      len   <= 5'd0;
      last  <= 1'b1;
      oGNT  <= 2'b00;
      oDONE <= 2'b00;
      oSIG  <= 1'b0;
      oBUSY <= 1'b0;
    end else begin
      state <= state_n;
      presc <= presc_n;
      step  <= step_n;
      len   <= len_n;
      last  <= last_n;
      oGNT  <= gnt_n;
      oDONE <= done_n;
      oSIG  <= sig_n;
      oBUSY <= busy_n;
    end
  end

  // Pattern copy is pure data and only meaningful while PLAY is active.
  always_ff @(posedge iCLK) begin
    pat <= pat_n;
  end

endmodule

// File: tb/tb_pattern_line_arbiter.sv
// Self-checking bench for pattern_line_arbiter: vector table, hand-built corner
// sequences and randomized frames checked against a frame-timing model.
module tb_pattern_line_arbiter;
  localparam int D  = 4;
  localparam int PW = 16;

  logic          iCLK = 1'b0;
  logic          iRST_N = 1'b0;
  logic [1:0]    iREQ = 2'b00;
  logic [PW-1:0] iPAT0 = '0, iPAT1 = '0;
  logic [4:0]    iLEN0 = '0, iLEN1 = '0;
  logic          iABORT = 1'b0;
  logic [1:0]    oGNT, oDONE;
  logic          oSIG, oBUSY;
  logic [3:0]    oSTEP;

  int errors = 0;
  int checks = 0;
  int ptr;

  pattern_line_arbiter #(.CLK_DIV(D), .PAT_W(PW)) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iREQ(iREQ), .iPAT0(iPAT0), .iPAT1(iPAT1),
    .iLEN0(iLEN0), .iLEN1(iLEN1), .iABORT(iABORT), .oGNT(oGNT), .oDONE(oDONE),
    .oSIG(oSIG), .oBUSY(oBUSY), .oSTEP(oSTEP)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    logic [1:0]  req;
    logic [15:0] pat0, pat1;
    logic [4:0]  len0, len1;
    logic [1:0]  gnt, done;
    logic        sig, busy;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic do_reset();
    iRST_N = 1'b0;
    tick();
    iRST_N = 1'b1;
    ptr = 1;
  endtask

  task automatic chk_quiet(input string name);
    chk({name, "_gnt"}, oGNT, 2'b00);
    chk({name, "_sig"}, oSIG, 1'b0);
    chk({name, "_busy"}, oBUSY, 1'b0);
    chk({name, "_step"}, oSTEP, 4'd0);
  endtask

  // Called one step after the grant edge E0; returns in the first IDLE cycle.
  task automatic check_frame(input int w, input logic [15:0] p, input int len, input bit scramble);
    logic [1:0] oh;
    oh = (w == 1) ? 2'b10 : 2'b01;
    for (int t = 1; t <= len * D; t++) begin
      int k;
      k = (t - 1) / D;
      chk("frame_gnt", oGNT, oh);
      chk("frame_sig", oSIG, p[k]);
      chk("frame_step", oSTEP, k);
      chk("frame_busy", oBUSY, 1'b1);
      chk("frame_done", oDONE, 2'b00);
      if (scramble) begin
        iREQ  = (t == len * D) ? 2'b00 : 2'($urandom_range(0, 3));
        iPAT0 = 16'($urandom);
        iPAT1 = 16'($urandom);
        iLEN0 = 5'($urandom);
        iLEN1 = 5'($urandom);
      end
      tick();
    end
    chk("end_done", oDONE, oh);
    for (int t = len * D + 1; t <= (len + 1) * D; t++) begin
      chk("gap_gnt", oGNT, 2'b00);
      chk("gap_sig", oSIG, 1'b0);
      chk("gap_busy", oBUSY, 1'b1);
      chk("gap_step", oSTEP, 4'd0);
      if (t > len * D + 1) chk("gap_done", oDONE, 2'b00);
      tick();
    end
    chk("idle_busy", oBUSY, 1'b0);
    chk("idle_done", oDONE, 2'b00);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{2'b01, 16'h0001, 16'h0000, 5'd3, 5'd3,  2'b01, 2'b00, 1'b1, 1'b1};
    vecs[1] = '{2'b11, 16'h0001, 16'h0002, 5'd3, 5'd3,  2'b10, 2'b00, 1'b0, 1'b1};
    vecs[2] = '{2'b11, 16'h0003, 16'h0001, 5'd3, 5'd3,  2'b01, 2'b00, 1'b1, 1'b1};
    vecs[3] = '{2'b10, 16'h0001, 16'h0001, 5'd3, 5'd0,  2'b00, 2'b10, 1'b0, 1'b0};
    vecs[4] = '{2'b11, 16'h0001, 16'h0001, 5'd0, 5'd3,  2'b00, 2'b01, 1'b0, 1'b0};
    vecs[5] = '{2'b11, 16'h0001, 16'h8001, 5'd5, 5'd20, 2'b10, 2'b00, 1'b1, 1'b1};
    vecs[6] = '{2'b00, 16'hFFFF, 16'hFFFF, 5'd3, 5'd3,  2'b00, 2'b00, 1'b0, 1'b0};

    // Reset state
    iRST_N = 1'b0;
    tick();
    chk_quiet("reset");
    chk("reset_done", oDONE, 2'b00);
    iRST_N = 1'b1;
    ptr = 1;

    // Vector table: first-cycle response from IDLE
    for (int i = 0; i < 7; i++) begin
      iREQ = vecs[i].req; iPAT0 = vecs[i].pat0; iPAT1 = vecs[i].pat1;
      iLEN0 = vecs[i].len0; iLEN1 = vecs[i].len1;
      tick();
      chk($sformatf("vec%0d_gnt", i), oGNT, vecs[i].gnt);
      chk($sformatf("vec%0d_done", i), oDONE, vecs[i].done);
      chk($sformatf("vec%0d_sig", i), oSIG, vecs[i].sig);
      chk($sformatf("vec%0d_busy", i), oBUSY, vecs[i].busy);
      iREQ = 2'b00; iABORT = 1'b1;
      tick();
      iABORT = 1'b0;
    end

    // Single 12-step frame from requester 0
    do_reset();
    iREQ = 2'b01; iPAT0 = 16'h0CDC; iLEN0 = 5'd12;
    tick();
    iREQ = 2'b00;
    check_frame(0, 16'h0CDC, 12, 1'b0);

    // Continuous tie alternates, 17 cycles per grant
    do_reset();
    iREQ = 2'b11; iPAT0 = 16'h0005; iPAT1 = 16'h0006; iLEN0 = 5'd3; iLEN1 = 5'd3;
    tick();
    for (int n = 0; n < 4; n++) begin
      check_frame(n % 2, (n % 2) ? 16'h0006 : 16'h0005, 3, 1'b0);
      if (n < 3) tick();
    end
    iREQ = 2'b00;
    tick();

    // Length clamp to PAT_W
    do_reset();
    iREQ = 2'b10; iPAT1 = 16'hFFFF; iLEN1 = 5'd20;
    tick();
    iREQ = 2'b00;
    check_frame(1, 16'hFFFF, 16, 1'b0);

    // Length-0 reject
    do_reset();
    iREQ = 2'b01; iLEN0 = 5'd0;
    tick();
    chk("rej_done", oDONE, 2'b01);
    chk_quiet("rej");
    iREQ = 2'b00;
    tick();
    chk("rej_done_clr", oDONE, 2'b00);
    chk_quiet("rej_after");

    // Abort in step 5, then tie goes to requester 1
    do_reset();
    iREQ = 2'b01; iPAT0 = 16'hFFFF; iLEN0 = 5'd12;
    tick();
    iREQ = 2'b00;
    repeat (21) tick();
    chk("abort_pre_step", oSTEP, 4'd5);
    iABORT = 1'b1;
    tick();
    iABORT = 1'b0;
    chk_quiet("abort");
    chk("abort_done", oDONE, 2'b00);
    iREQ = 2'b11; iLEN1 = 5'd3;
    tick();
    chk("abort_tie_gnt", oGNT, 2'b10);
    iREQ = 2'b00; iABORT = 1'b1;
    tick();
    iABORT = 1'b0;
    chk_quiet("abort2");

    // Asynchronous reset mid-PLAY
    do_reset();
    iREQ = 2'b01; iPAT0 = 16'hFFFF; iLEN0 = 5'd10;
    tick();
    iREQ = 2'b00;
    repeat (10) tick();
    chk("pre_rst_sig", oSIG, 1'b1);
    iRST_N = 1'b0;
    #1;
    chk_quiet("async_rst");
    chk("async_rst_done", oDONE, 2'b00);
    tick();
    iRST_N = 1'b1;
    ptr = 1;
    iREQ = 2'b11; iLEN1 = 5'd3;
    tick();
    chk("rst_tie_gnt", oGNT, 2'b01);
    iREQ = 2'b00; iABORT = 1'b1;
    tick();
    iABORT = 1'b0;

    // Randomized frames against the scheduling model
    do_reset();
    for (int n = 0; n < 24; n++) begin
      logic [1:0]  r;
      logic [15:0] p0, p1;
      int          l0, l1, w, wl;
      r  = 2'($urandom_range(0, 3));
      p0 = 16'($urandom);
      p1 = 16'($urandom);
      l0 = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 20);
      l1 = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 20);
      iREQ = r; iPAT0 = p0; iPAT1 = p1; iLEN0 = 5'(l0); iLEN1 = 5'(l1);
      tick();
      if (r == 2'b00) begin
        chk_quiet("rnd_none");
        chk("rnd_none_done", oDONE, 2'b00);
      end else begin
        if (r == 2'b01)      w = 0;
        else if (r == 2'b10) w = 1;
        else                 w = (ptr == 1) ? 0 : 1;
        ptr = w;
        wl = (w == 1) ? l1 : l0;
        if (wl == 0) begin
          chk("rnd_rej_done", oDONE, (w == 1) ? 2'b10 : 2'b01);
          chk_quiet("rnd_rej");
          iREQ = 2'b00;
          tick();
        end else begin
          check_frame(w, (w == 1) ? p1 : p0, (wl > PW) ? PW : wl, 1'b1);
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
